// File: rtl/writeback_arbiter.sv
// Multi-producer writeback stage.
// Each producer channel has its own DEPTH-entry FIFO. A round-robin arbiter
// drains the FIFOs onto the single register-file write port.
// The pending mask lists every register that still has a write buffered or
// currently on the port, so the hazard unit can stall readers of it.
module writeback_arbiter #(
    parameter int NCH   = 2,
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH*5-1:0]     in_rd,
    input  logic [NCH*XLEN-1:0]  in_data,
    output logic                 wen,
    output logic [4:0]           waddr,
    output logic [XLEN-1:0]      wdata,
    output logic [31:0]          pending,
    output logic [31:0]          retire_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    // Per-channel FIFO storage and bookkeeping
    logic [4:0]      fifo_rd   [NCH][DEPTH];
    logic [XLEN-1:0] fifo_data [NCH][DEPTH];
    logic [PW-1:0]   rd_ptr    [NCH];
    logic [PW-1:0]   wr_ptr    [NCH];
    logic [CW-1:0]   count     [NCH];

    logic [NCH-1:0]  push;
    logic [NCH-1:0]  pop;
    logic [NCH-1:0]  nonempty;

    // Arbitration state and result
    logic [GW-1:0]   last_grant;
    logic            grant_valid;
    logic [GW-1:0]   grant_idx;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    logic [31:0]     retire_q;
    logic [PW-1:0]   offset;

    // Ready depends only on registered occupancy; x0 writes are accepted but dropped
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = !reset && (count[i] != CW'(DEPTH));
            push[i]     = in_valid[i] && in_ready[i] && (in_rd[5*i +: 5] != 5'd0);
            nonempty[i] = (count[i] != '0);
        end
    end

    // Round-robin search: first channels above last_grant, then wrap to the rest
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        head_rd     = '0;
        head_data   = '0;
        for (int j = 0; j < NCH; j++) begin
            if (!grant_valid && (j > int'(last_grant)) && nonempty[j]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(j);
                head_rd     = fifo_rd[j][rd_ptr[j]];
                head_data   = fifo_data[j][rd_ptr[j]];
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (!grant_valid && (j <= int'(last_grant)) && nonempty[j]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(j);
                head_rd     = fifo_rd[j][rd_ptr[j]];
                head_data   = fifo_data[j][rd_ptr[j]];
            end
        end
    end

    // One-hot pop for the winning channel
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pop[i] = grant_valid && (grant_idx == GW'(i));
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave count unchanged
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end else begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; validity comes from the reset pointers and counts.
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) begin
                fifo_rd[i][wr_ptr[i]]   <= in_rd[5*i +: 5];
                fifo_data[i][wr_ptr[i]] <= in_data[XLEN*i +: XLEN];
            end
        end
    end

    // Registered write port, grant history and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wen        <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            last_grant <= '0;
            retire_q   <= '0;
        end else begin
            wen <= grant_valid;
            if (grant_valid) begin
                waddr      <= head_rd;
                wdata      <= head_data;
                last_grant <= grant_idx;
                retire_q   <= retire_q + 32'd1;
            end
        end
    end

    assign retire_count = retire_q;

    // Pending mask: every occupied FIFO slot plus the write currently on the port
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pending = '0;
        offset  = '0;
        for (int i = 0; i < NCH; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                offset = PW'(k) - rd_ptr[i];
                if ({1'b0, offset} < count[i]) pending[fifo_rd[i][k]] = 1'b1;
            end
        end
        if (wen) pending[waddr] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios followed by a random
// phase, every cycle checked against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int NCH   = 2;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [NCH-1:0]      in_valid;
    logic [NCH-1:0]      in_ready;
    logic [NCH*5-1:0]    in_rd;
    logic [NCH*XLEN-1:0] in_data;
    logic                wen;
    logic [4:0]          waddr;
    logic [XLEN-1:0]     wdata;
    logic [31:0]         pending;
    logic [31:0]         retire_count;

    always #5 clk = ~clk;

    writeback_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_data      (in_data),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .pending      (pending),
        .retire_count (retire_count)
    );

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } req_t;

    // Producers' outstanding requests and the model's view of each FIFO
    req_t src [NCH][$];
    req_t mq  [NCH][$];

    int          last_g;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_retire;

    int          checks;
    int          errors;
    logic [4:0]  wlog [$];
    logic        ready_low_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < NCH; i++)
            foreach (mq[i][j]) p[mq[i][j].rd] = 1'b1;
        if (exp_wen) p[exp_waddr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) mq[i].delete();
        last_g     = 0;
        exp_wen    = 1'b0;
        exp_waddr  = '0;
        exp_wdata  = '0;
        exp_retire = '0;
    endfunction

    // One clock: drive producers, check pre-edge outputs, step model, check post-edge outputs
    task automatic cycle();
        logic [NCH-1:0] acc;
        logic           exp_rdy;
        int             win;
        int             c;
        req_t           r;
        for (int i = 0; i < NCH; i++) begin
            in_valid[i] = (src[i].size() > 0);
            if (src[i].size() > 0) begin
                in_rd[5*i +: 5]          = src[i][0].rd;
                in_data[XLEN*i +: XLEN]  = src[i][0].data;
            end
        end
        #1;
        for (int i = 0; i < NCH; i++) begin
            exp_rdy = !reset && (mq[i].size() != DEPTH);
            check("in_ready", 64'(in_ready[i]), 64'(exp_rdy));
            acc[i] = in_valid[i] && exp_rdy;
            if (i == 0 && !reset && in_ready[0] === 1'b0) ready_low_seen = 1'b1;
        end
        check("pending", 64'(pending), 64'(model_pending()));
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            win = -1;
            for (int k = 1; k <= NCH; k++) begin
                c = (last_g + k) % NCH;
                if (win < 0 && mq[c].size() > 0) win = c;
            end
            if (win >= 0) begin
                r          = mq[win].pop_front();
                exp_wen    = 1'b1;
                exp_waddr  = r.rd;
                exp_wdata  = r.data;
                last_g     = win;
                exp_retire = exp_retire + 32'd1;
            end else begin
                exp_wen = 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (acc[i]) begin
                    r = src[i].pop_front();
                    if (r.rd != 5'd0) mq[i].push_back(r);
                end
            end
        end
        #1;
        check("wen",          64'(wen),          64'(exp_wen));
        check("waddr",        64'(waddr),        64'(exp_waddr));
        check("wdata",        64'(wdata),        64'(exp_wdata));
        check("retire_count", 64'(retire_count), 64'(exp_retire));
        if (wen === 1'b1) wlog.push_back(waddr);
    endtask

    // Bounded run time regardless of what the DUT does
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rr_exp [8];
        logic [4:0] ch0_seq [$];
        req_t       rq;

        checks = 0;
        errors = 0;
        ready_low_seen = 1'b0;
        reset    = 1'b1;
        in_valid = '0;
        in_rd    = '0;
        in_data  = '0;
        model_reset();

        // Reset: first edge initialises state, then two checked reset cycles
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check("reset_wen",     64'(wen),          64'd0);
        check("reset_pending", 64'(pending),      64'd0);
        check("reset_retire",  64'(retire_count), 64'd0);
        check("reset_ready",   64'(in_ready),     64'd0);
        reset = 1'b0;

        // Single write, one-cycle latency
        src[0].push_back(req_t'{rd: 5'd5, data: 32'hDEADBEEF});
        cycle();
        check("single_pend_acc", 64'(pending[5]), 64'd1);
        check("single_no_bypass", 64'(wen), 64'd0);
        cycle();
        check("single_wen",   64'(wen),        64'd1);
        check("single_waddr", 64'(waddr),      64'd5);
        check("single_wdata", 64'(wdata),      64'hDEADBEEF);
        check("single_pend_port", 64'(pending[5]), 64'd1);
        cycle();
        check("single_pend_clear", 64'(pending[5]), 64'd0);
        check("single_retire", 64'(retire_count), 64'd1);

        // x0 writes are accepted but produce nothing
        src[1].push_back(req_t'{rd: 5'd0, data: 32'h12345678});
        cycle();
        check("x0_taken", 64'(src[1].size()), 64'd0);
        cycle();
        check("x0_wen",     64'(wen),          64'd0);
        check("x0_pending", 64'(pending),      64'd0);
        check("x0_retire",  64'(retire_count), 64'd1);

        // Round-robin fairness from a fresh reset
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) src[0].push_back(req_t'{rd: 5'(1 + k), data: 32'(100 + k)});
        cycle();
        for (int k = 0; k < 4; k++) src[1].push_back(req_t'{rd: 5'(11 + k), data: 32'(200 + k)});
        wlog.delete();
        repeat (8) cycle();
        rr_exp = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
        check("rr_count", 64'(wlog.size()), 64'd8);
        for (int k = 0; k < 8; k++)
            if (k < wlog.size()) check("rr_order", 64'(wlog[k]), 64'(rr_exp[k]));
        cycle();

        // Backpressure: ch0 fills while ch1 keeps competing
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        ready_low_seen = 1'b0;
        for (int k = 0; k < 3; k++) src[0].push_back(req_t'{rd: 5'(20 + k), data: 32'(300 + k)});
        for (int k = 0; k < 6; k++) src[1].push_back(req_t'{rd: 5'd7, data: 32'(400 + k)});
        wlog.delete();
        repeat (12) cycle();
        check("full_ready_low", 64'(ready_low_seen), 64'd1);
        foreach (wlog[k]) if (wlog[k] >= 5'd20) ch0_seq.push_back(wlog[k]);
        check("full_ch0_count", 64'(ch0_seq.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            if (k < ch0_seq.size()) check("full_ch0_order", 64'(ch0_seq[k]), 64'(20 + k));

        // Reset mid-operation discards everything buffered
        for (int k = 0; k < 6; k++) begin
            src[0].push_back(req_t'{rd: 5'(3 + k), data: $urandom});
            src[1].push_back(req_t'{rd: 5'(16 + k), data: $urandom});
        end
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check("mid_reset_wen",     64'(wen),     64'd0);
        check("mid_reset_pending", 64'(pending), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) src[i].delete();
        wlog.delete();
        repeat (4) cycle();
        check("mid_reset_no_stale", 64'(wlog.size()), 64'd0);
        check("mid_reset_ready",    64'(in_ready),    64'(2'b11));

        // Retire counter wrap via backdoor preload
        dut.retire_q = 32'hFFFF_FFFF;
        exp_retire   = 32'hFFFF_FFFF;
        src[0].push_back(req_t'{rd: 5'd9, data: 32'hCAFEF00D});
        cycle();
        cycle();
        check("wrap_wen",    64'(wen),          64'd1);
        check("wrap_retire", 64'(retire_count), 64'd0);

        // Random traffic with occasional resets, including x0 destinations
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if (src[i].size() < 3 && $urandom_range(0, 1) == 1) begin
                    rq.rd   = 5'($urandom_range(0, 31));
                    rq.data = $urandom;
                    src[i].push_back(rq);
                end
            end
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;

        // Drain with a bounded budget
        for (int n = 0; n < 40; n++) cycle();
        check("drain_src0", 64'(src[0].size()), 64'd0);
        check("drain_src1", 64'(src[1].size()), 64'd0);
        check("drain_wen",  64'(wen),           64'd0);
        check("drain_pending", 64'(pending),    64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
